// File: rtl/entry_parking_lot_pkg.sv
// Shared sizing defaults and FSM encoding for the entry parking lot controller.
package entry_parking_lot_pkg;
  localparam int NUM_SPOTS_D   = 8;
  localparam int PARK_W_D      = 3;
  localparam int GATE_CYCLES_D = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSIGN = 2'd1,
    GATE   = 2'd2
  } state_e;
endpackage

// File: rtl/entry_parking_lot_if.sv
// Entry/exit handshake bundle between the lot controller and its environment.
interface entry_parking_lot_if #(
  parameter int NUM_SPOTS = entry_parking_lot_pkg::NUM_SPOTS_D,
  parameter int PARK_W    = entry_parking_lot_pkg::PARK_W_D
);
  logic                 car_arrive;
  logic                 exit_valid;
  logic [PARK_W-1:0]    exit_number;
  logic [PARK_W-1:0]    park_number;
  logic                 park_valid;
  logic [NUM_SPOTS-1:0] park_location;
  logic                 gate_open;
  logic                 reject;
  logic                 exit_error;
  logic [3:0]           free_count;
  logic                 full;

  modport master (
    output car_arrive, exit_valid, exit_number,
    input  park_number, park_valid, park_location, gate_open,
           reject, exit_error, free_count, full
  );

  modport slave (
    input  car_arrive, exit_valid, exit_number,
    output park_number, park_valid, park_location, gate_open,
           reject, exit_error, free_count, full
  );
endinterface

// File: rtl/free_spot_finder.sv
// Combinational priority encoder: index of the lowest clear bit in the occupancy vector.
module free_spot_finder #(
  parameter int NUM_SPOTS = entry_parking_lot_pkg::NUM_SPOTS_D,
  parameter int PARK_W    = entry_parking_lot_pkg::PARK_W_D
) (
  input  logic [NUM_SPOTS-1:0] occ,
  output logic [PARK_W-1:0]    idx,
  output logic                 found
);
  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_SPOTS-1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx   = PARK_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/entry_parking_lot.sv
// Parking lot entry controller: admits cars to the lowest free spot, opens the gate, tracks exits.
module entry_parking_lot
  import entry_parking_lot_pkg::*;
#(
  parameter int NUM_SPOTS   = NUM_SPOTS_D,
  parameter int PARK_W      = PARK_W_D,
  parameter int GATE_CYCLES = GATE_CYCLES_D
) (
  input  logic          clk,
  input  logic          rst_n,
  entry_parking_lot_if.slave bus
);
  localparam int              CNT_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_e               state;
  logic [NUM_SPOTS-1:0] loc;
  logic [PARK_W-1:0]    pnum;
  logic                 pvld, rej, xerr, gate;
  logic [CNT_W-1:0]     cnt;

  logic [PARK_W-1:0]    free_idx;
  logic                 free_found;
  logic                 lot_full;
  logic                 exit_hit;
  logic [NUM_SPOTS-1:0] exit_mask;
  logic [NUM_SPOTS-1:0] alloc_mask;
  logic [3:0]           occupied;

  free_spot_finder #(.NUM_SPOTS(NUM_SPOTS), .PARK_W(PARK_W)) u_finder (
    .occ   (loc),
    .idx   (free_idx),
    .found (free_found)
  );

  assign lot_full   = &loc;
  assign exit_hit   = bus.exit_valid & loc[bus.exit_number];
  assign exit_mask  = exit_hit ? (NUM_SPOTS'(1) << bus.exit_number) : '0;
  assign alloc_mask = NUM_SPOTS'(1) << free_idx;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_SPOTS; i++) occupied = occupied + 4'(loc[i]);
  end

  // Exits are applied in every state; ASSIGN folds its allocation in with the same write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      loc   <= '0;
      pnum  <= '0;
      pvld  <= 1'b0;
      rej   <= 1'b0;
      xerr  <= 1'b0;
      gate  <= 1'b0;
      cnt   <= '0;
    end else begin
      pvld <= 1'b0;
      rej  <= 1'b0;
      xerr <= bus.exit_valid & ~loc[bus.exit_number];
      loc  <= loc & ~exit_mask;
      case (state)
        IDLE: begin
          if (bus.car_arrive) begin
            if (lot_full) rej   <= 1'b1;
            else          state <= ASSIGN;
          end
        end
        ASSIGN: begin
          if (free_found) begin
            pnum  <= free_idx;
            loc   <= (loc | alloc_mask) & ~exit_mask;
            pvld  <= 1'b1;
            gate  <= 1'b1;
            cnt   <= '0;
            state <= GATE;
          end else begin
            rej   <= 1'b1;
            state <= IDLE;
          end
        end
        GATE: begin
          if (cnt == GATE_LAST) begin
            gate  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.park_number   = pnum;
  assign bus.park_valid    = pvld;
  assign bus.park_location = loc;
  assign bus.gate_open     = gate;
  assign bus.reject        = rej;
  assign bus.exit_error    = xerr;
  assign bus.free_count    = 4'(NUM_SPOTS) - occupied;
  assign bus.full          = lot_full;
endmodule
